// File: rtl/ppwm_seq.sv
// Duty-cycle sequencer: steps a small duty table into the PWM datapath at each
// period boundary, then returns the datapath to a programmable idle duty.
module ppwm_seq #(
    parameter int unsigned N_STEPS = 8,
    parameter int unsigned DW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [7:0]    cfg_wdata,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          period_end_i,
    output logic [DW-1:0] duty_o,
    output logic          duty_load_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned IW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int unsigned LW = 4;
    localparam int unsigned CW = 8;
    localparam logic [3:0] ADDR_LEN  = 4'd8;
    localparam logic [3:0] ADDR_RPT  = 4'd9;
    localparam logic [3:0] ADDR_IDLE = 4'd10;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

    state_t        state, state_d;
    logic [DW-1:0] tab [N_STEPS];
    logic [LW-1:0] len_reg;
    logic [CW-1:0] rpt_reg;
    logic [DW-1:0] idle_duty;

    logic [LW-1:0] len_w, len_w_d;
    logic [CW-1:0] rpt_w, rpt_w_d;
    logic [IW-1:0] idx, idx_d;
    logic [CW-1:0] pass_cnt, pass_cnt_d;
    logic [DW-1:0] duty_d;
    logic          load_d, done_d, busy_d;

    logic          tab_we_c, idle_we_c;
    logic [LW-1:0] len_eff_c;
    logic [IW-1:0] idx_last_c, idx_nxt_c;
    logic [CW-1:0] pass_inc_c;

    assign tab_we_c   = cfg_we && (cfg_addr < 4'(N_STEPS));
    assign idle_we_c  = cfg_we && (cfg_addr == ADDR_IDLE);
    assign idx_last_c = IW'(len_w - LW'(1));
    assign idx_nxt_c  = idx + IW'(1);
    assign pass_inc_c = pass_cnt + CW'(1);

    // LEN of 0 behaves as 1; anything past the table size is clamped
    always_comb begin
        len_eff_c = len_reg;
        if (len_reg == '0)
            len_eff_c = LW'(1);
        else if (len_reg > LW'(N_STEPS))
            len_eff_c = LW'(N_STEPS);
    end

    // Configuration registers; table accepts writes in any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_STEPS); i++) tab[i] <= '0;
            len_reg   <= '0;
            rpt_reg   <= '0;
            idle_duty <= '0;
        end else begin
            if (tab_we_c)                          tab[cfg_addr[IW-1:0]] <= cfg_wdata[DW-1:0];
            if (cfg_we && cfg_addr == ADDR_LEN)    len_reg   <= cfg_wdata[LW-1:0];
            if (cfg_we && cfg_addr == ADDR_RPT)    rpt_reg   <= cfg_wdata;
            if (idle_we_c)                         idle_duty <= cfg_wdata[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            len_w       <= '0;
            rpt_w       <= '0;
            idx         <= '0;
            pass_cnt    <= '0;
            duty_o      <= '0;
            duty_load_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_d;
            len_w       <= len_w_d;
            rpt_w       <= rpt_w_d;
            idx         <= idx_d;
            pass_cnt    <= pass_cnt_d;
            duty_o      <= duty_d;
            duty_load_o <= load_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
        end
    end

    // Next state plus next values of the registered outputs
    always_comb begin
        state_d    = state;
        len_w_d    = len_w;
        rpt_w_d    = rpt_w;
        idx_d      = idx;
        pass_cnt_d = pass_cnt;
        duty_d     = duty_o;
        load_d     = 1'b0;
        done_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (idle_we_c) begin
                    duty_d = cfg_wdata[DW-1:0];
                    load_d = 1'b1;
                end
                if (start_i && !stop_i) begin
                    len_w_d    = len_eff_c;
                    rpt_w_d    = rpt_reg;
                    idx_d      = '0;
                    pass_cnt_d = '0;
                    state_d    = ST_ARM;
                end
            end
            ST_ARM, ST_RUN: begin
                if (stop_i) begin
                    duty_d  = idle_duty;
                    load_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (period_end_i) begin
                    load_d = 1'b1;
                    if (state == ST_ARM) begin
                        duty_d  = tab[0];
                        idx_d   = '0;
                        state_d = ST_RUN;
                    end else if (idx == idx_last_c) begin
                        if (rpt_w != '0) pass_cnt_d = pass_inc_c;
                        if (rpt_w != '0 && pass_inc_c == rpt_w) begin
                            duty_d  = idle_duty;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            duty_d = tab[0];
                            idx_d  = '0;
                        end
                    end else begin
                        duty_d = tab[idx_nxt_c];
                        idx_d  = idx_nxt_c;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_ppwm_seq.sv
// Bench for ppwm_seq: directed scenarios plus randomized patterns, checked
// against an arithmetic model of which duty each period_end pulse should load.
module tb_ppwm_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       period_end_i = 1'b0;
    logic [7:0] duty_o;
    logic       duty_load_o, busy_o, done_o;

    int errors = 0;
    int checks = 0;

    // bench-side picture of the register file
    logic [7:0] mdl_tab [8];
    int         mdl_len, mdl_rpt;
    logic [7:0] mdl_idle;
    // snapshot of the running pattern
    int         run_eff, run_rpt, run_k;
    bit         running, fin;

    ppwm_seq #(.N_STEPS(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start_i(start_i), .stop_i(stop_i),
        .period_end_i(period_end_i), .duty_o(duty_o), .duty_load_o(duty_load_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        if (l > 8) return 8;
        return l;
    endfunction

    function automatic logic [7:0] exp_duty(input int k);
        if (run_rpt != 0 && k > run_rpt * run_eff) return mdl_idle;
        return mdl_tab[(k - 1) % run_eff];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl_tab[i] = '0;
        mdl_len = 0; mdl_rpt = 0; mdl_idle = '0; running = 0;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = 8'(data);
        tick();
        cfg_we = 1'b0;
        if (addr < 8) mdl_tab[addr] = 8'(data);
        else if (addr == 8) mdl_len = data & 15;
        else if (addr == 9) mdl_rpt = data & 255;
        else if (addr == 10) begin
            mdl_idle = 8'(data);
            if (!running) begin
                chk("idle_wr_load", 32'(duty_load_o), 1);
                chk("idle_wr_duty", 32'(duty_o), 32'(mdl_idle));
            end
        end
    endtask

    task automatic do_start(input bit with_pe);
        start_i = 1'b1; period_end_i = with_pe;
        tick();
        start_i = 1'b0; period_end_i = 1'b0;
        run_eff = eff_len(mdl_len); run_rpt = mdl_rpt; run_k = 0; running = 1;
        chk("start_busy", 32'(busy_o), 1);
        chk("start_noload", 32'(duty_load_o), 0);
    endtask

    task automatic do_pulse();
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            tick();
            chk("gap_noload", 32'(duty_load_o), 0);
        end
        period_end_i = 1'b1;
        tick();
        period_end_i = 1'b0;
        run_k++;
        fin = (run_rpt != 0) && (run_k == run_rpt * run_eff + 1);
        chk("pulse_load", 32'(duty_load_o), 1);
        chk("pulse_duty", 32'(duty_o), 32'(exp_duty(run_k)));
        chk("pulse_done", 32'(done_o), 32'(fin));
        chk("pulse_busy", 32'(busy_o), 32'(!fin));
        if (fin) running = 0;
    endtask

    task automatic do_stop(input bit with_pe);
        stop_i = 1'b1; period_end_i = with_pe;
        tick();
        stop_i = 1'b0; period_end_i = 1'b0;
        running = 0;
        chk("stop_load", 32'(duty_load_o), 1);
        chk("stop_duty", 32'(duty_o), 32'(mdl_idle));
        chk("stop_done", 32'(done_o), 0);
        chk("stop_busy", 32'(busy_o), 0);
    endtask

    initial begin
        model_reset();
        #17;
        chk("rst_duty", 32'(duty_o), 0);
        chk("rst_load", 32'(duty_load_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        rst_n = 1'b1;
        tick();

        // three-step table, two passes
        cfg_write(0, 10); cfg_write(1, 20); cfg_write(2, 30);
        cfg_write(8, 3); cfg_write(9, 2); cfg_write(10, 5);
        do_start(0);
        for (int i = 0; i < 7; i++) do_pulse();
        chk("p1_finished", 32'(fin), 1);
        tick();
        chk("p1_idle_busy", 32'(busy_o), 0);
        chk("p1_idle_done", 32'(done_o), 0);

        // LEN=0 behaves as one step
        cfg_write(8, 0); cfg_write(9, 3); cfg_write(0, 77);
        do_start(0);
        for (int i = 0; i < 4; i++) do_pulse();
        chk("p2_finished", 32'(fin), 1);

        // infinite repeat, then stop
        cfg_write(9, 0); cfg_write(8, 2); cfg_write(0, 1); cfg_write(1, 2);
        do_start(0);
        for (int i = 0; i < 20; i++) do_pulse();
        chk("p3_still_busy", 32'(busy_o), 1);
        do_stop(0);

        // start with period_end in the same cycle, restart ignored, stop beats period_end
        cfg_write(8, 3); cfg_write(0, 40); cfg_write(1, 41); cfg_write(2, 42);
        do_start(1);
        do_pulse();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_noload", 32'(duty_load_o), 0);
        chk("restart_busy", 32'(busy_o), 1);
        do_pulse();
        do_stop(1);

        // mid-run table and LEN writes
        cfg_write(0, 11); cfg_write(1, 22); cfg_write(2, 33);
        cfg_write(8, 3); cfg_write(9, 1); cfg_write(10, 6);
        do_start(0);
        do_pulse();
        cfg_write(1, 99);
        do_pulse();
        chk("tab_update_99", 32'(duty_o), 99);
        // write of entry 2 coinciding with its load: old value is loaded
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 8'd55; period_end_i = 1'b1;
        tick();
        cfg_we = 1'b0; period_end_i = 1'b0;
        run_k++;
        chk("same_cycle_wr_load", 32'(duty_load_o), 1);
        chk("same_cycle_wr_old", 32'(duty_o), 33);
        mdl_tab[2] = 8'd55;
        cfg_write(8, 1);
        do_pulse();
        chk("len_unchanged_done", 32'(fin), 1);

        // randomized patterns
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 8; a++) cfg_write(a, $urandom_range(0, 255));
            cfg_write(8, $urandom_range(0, 15));
            cfg_write(9, $urandom_range(1, 3));
            cfg_write(10, $urandom_range(0, 255));
            do_start(0);
            for (int p = 0; p < 30 && running; p++) do_pulse();
            chk("rand_finished", 32'(fin), 1);
        end

        // asynchronous reset in the middle of a run
        cfg_write(0, 42); cfg_write(8, 2); cfg_write(9, 0);
        do_start(0);
        do_pulse();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_duty", 32'(duty_o), 0);
        chk("arst_load", 32'(duty_load_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_done", 32'(done_o), 0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_load", 32'(duty_load_o), 0);
        chk("post_rst_busy", 32'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
